// File: rtl/lvds_rx_pkg.sv
// rtl/lvds_rx_pkg.sv - shared state enum and parameter defaults for the LVDS receive monitor
package lvds_rx_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_LEN_DEF    = 4;
  localparam int TIMEOUT_DEF     = 2**24;
  localparam int PER_W_DEF       = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LOST   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/TLVDS_IBUF.sv
// rtl/TLVDS_IBUF.sv - behavioural stand-in for the vendor differential input buffer
module TLVDS_IBUF (
  input  logic I,
  input  logic IB,
  output logic O
);

  // A 1-bit differential comparator: high only when the true leg is above the complement leg
  assign O = I & ~IB;

endmodule

// File: rtl/lvds_rx_filt.sv
// rtl/lvds_rx_filt.sv - run-length glitch filter producing the accepted level and edge pulse
module lvds_rx_filt
  import lvds_rx_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic edge_pulse,
  output logic accept
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  logic [3:0] cnt;

  // The level flips on the cycle the disagreement run would reach FILT_LEN
  assign accept = (din != level) && (cnt == CNT_LAST);

  // Disagreement counter, accepted level and one-cycle edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      level      <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= accept;
      if (accept) begin
        level <= ~level;
        cnt   <= 4'd0;
      end else if (din != level) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/lvds_rx_mon.sv
// rtl/lvds_rx_mon.sv - LVDS receive monitor: sync, filter, activity FSM, optional period (LVDS_RX_PERIOD_EN)
module lvds_rx_mon
  import lvds_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int PER_W       = PER_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tlvds_p,
  input  logic             tlvds_n,
  output logic             rx_level_o,
  output logic             edge_o,
  output logic             active_o,
  output logic             lost_o
`ifdef LVDS_RX_PERIOD_EN
  ,
  output logic [PER_W-1:0] period_o,
  output logic             period_vld_o
`endif
);

  localparam int               SIL_W   = $clog2(TIMEOUT + 1);
  localparam logic [SIL_W-1:0] SIL_MAX = SIL_W'(TIMEOUT);

  logic                   pad_se;
  logic [1:0]             rst_pipe;
  logic                   rst_int;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   accept;
  logic [SIL_W-1:0]       sil;
  logic [SIL_W-1:0]       sil_next;
  logic                   timeout_hit;
  rx_state_t              state;
  rx_state_t              state_next;

  TLVDS_IBUF u_ibuf (
    .I  (tlvds_p),
    .IB (tlvds_n),
    .O  (pad_se)
  );

  // Reset asserts immediately but releases only on a clk edge, two flops deep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_int = rst_pipe[1];

  // Metastability chain from the single-ended buffer output
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pad_se};
  end

  lvds_rx_filt #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .clk        (clk),
    .rst_n      (rst_int),
    .din        (sync_q[SYNC_STAGES-1]),
    .level      (rx_level_o),
    .edge_pulse (edge_o),
    .accept     (accept)
  );

  // Silence count is zero while edge_o is high, so an edge always pre-empts the timeout
  always_comb begin
    sil_next = sil;
    if (accept)              sil_next = '0;
    else if (sil != SIL_MAX) sil_next = sil + 1'b1;
  end
  assign timeout_hit = (sil_next == SIL_MAX);

  // Silence counter register
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) sil <= '0;
    else          sil <= sil_next;
  end

  // Activity state register
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) state <= IDLE;
    else          state <= state_next;
  end

  // Activity next-state: edges activate, silence only demotes ACTIVE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (edge_o) state_next = ACTIVE;
      ACTIVE:  if (!edge_o && timeout_hit) state_next = LOST;
      LOST:    if (edge_o) state_next = ACTIVE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decode the registered state
  always_comb begin
    active_o = (state == ACTIVE);
    lost_o   = (state == LOST);
  end

`ifdef LVDS_RX_PERIOD_EN
  logic [PER_W-1:0] per_cnt;
  logic             armed;
  logic             rise;

  assign rise = edge_o & rx_level_o;

  // Rising-to-rising period; a rise with no armed reference only restarts the count
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      per_cnt      <= '0;
      armed        <= 1'b0;
      period_o     <= '0;
      period_vld_o <= 1'b0;
    end else begin
      period_vld_o <= 1'b0;
      if (rise) begin
        per_cnt <= PER_W'(1);
        if (armed && state != LOST) begin
          period_o     <= per_cnt;
          period_vld_o <= 1'b1;
        end
        armed <= 1'b1;
      end else begin
        if (per_cnt != '1) per_cnt <= per_cnt + 1'b1;
        if (state == LOST) armed <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: doc/lvds_rx_mon.md
LVDS_RX_MON -- requirements
Module: lvds_rx_mon

Interface
- REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops after the input buffer (legal range 2..4).
- REQ-002 Parameter FILT_LEN, default 4: consecutive identical samples required to accept a level change (legal range 1..15).
- REQ-003 Parameter TIMEOUT, default 2**24: clk cycles without an accepted edge before loss is declared (legal range ≥2).
- REQ-004 Parameter PER_W, default 26: width of the period measurement.
- REQ-005 clk  input  1  system clock; all logic on rising edge.
- REQ-006 rst_n  input  1  asynchronous active-low reset.
- REQ-007 tlvds_p  input  1  differential pad, true leg.
- REQ-008 tlvds_n  input  1  differential pad, complement leg.
- REQ-009 rx_level_o  output  1  filtered received level.
- REQ-010 edge_o  output  1  one-cycle pulse on every accepted level change.
- REQ-011 active_o  output  1  high while in state ACTIVE.
- REQ-012 lost_o  output  1  high while in state LOST.
- REQ-013 period_o  output  PER_W  cycles between the last two accepted rising edges (LVDS_RX_PERIOD_EN only).
- REQ-014 period_vld_o  output  1  one-cycle strobe when period_o updates (LVDS_RX_PERIOD_EN only).

Function
- REQ-015 Pads enter one TLVDS_IBUF; its single-ended output feeds a SYNC_STAGES flop chain; no other logic touches the pads.
- REQ-016 Filter: a counter increments while the synchronized bit differs from rx_level_o and clears when they match; on the cycle the count would reach FILT_LEN, rx_level_o toggles and the count clears.
- REQ-017 Latency: a pad change stable ≥FILT_LEN cycles appears on rx_level_o exactly SYNC_STAGES+FILT_LEN cycles later; pulses shorter than FILT_LEN cycles never reach rx_level_o.
- REQ-018 edge_o asserts in the same cycle rx_level_o changes, for exactly one cycle.
- REQ-019 A silence counter clears on edge_o, otherwise increments, and saturates at TIMEOUT.
- REQ-020 States: IDLE (after reset), ACTIVE, LOST; IDLE->ACTIVE and LOST->ACTIVE on edge_o; ACTIVE->LOST when the silence counter reaches TIMEOUT; IDLE never moves to LOST.
- REQ-021 If edge_o and the timeout occur in the same cycle, the edge wins: the state is or stays ACTIVE.
- REQ-022 active_o and lost_o decode the registered state; they are never high together.
- REQ-023 Period: a counter starts at 1 on an accepted rising edge, increments each cycle, and saturates at all-ones; on the next accepted rising edge period_o loads the count and period_vld_o pulses.
- REQ-024 The first rising edge after reset or after LOST only restarts the counter and issues no period_vld_o.

Reset
- REQ-025 rst_n low asynchronously clears all flops: rx_level_o=0, edge_o=0, active_o=0, lost_o=0, period_o=0, period_vld_o=0, state=IDLE, synchronizer=0.
- REQ-026 Reset asserted mid-measurement discards the partial count; the deassertion is synchronized to clk internally.

Configuration
- REQ-027 With LVDS_RX_PERIOD_EN defined, REQ-023/024 logic and ports period_o/period_vld_o exist.
- REQ-028 Without LVDS_RX_PERIOD_EN, those ports are absent and no period counter is built; all other behaviour is unchanged.

Structure
- REQ-029 The shared package lvds_rx_pkg holds the state enum (IDLE, ACTIVE, LOST) and the parameter default constants.
- REQ-030 The filter (REQ-016/017) is a sub-module lvds_rx_filt; the rest is flat in lvds_rx_mon.

Verification (SYNC_STAGES=2, FILT_LEN=4, TIMEOUT=64, macro defined)
- REQ-031 Reset release, pads idle at 0 -> all outputs 0, state IDLE for 200 cycles, lost_o never set.
- REQ-032 Pad rises and holds -> rx_level_o=1 and edge_o pulse exactly 6 cycles later; active_o=1 on the next cycle.
- REQ-033 Pad glitch of 3 cycles -> no edge_o and rx_level_o unchanged; glitch of 4 cycles -> one accepted edge.
- REQ-034 Square wave with period 20 cycles -> after the second rising edge period_o=20 with period_vld_o pulses; first edge gives no strobe.
- REQ-035 Wave stops after ACTIVE -> lost_o=1 exactly 64 cycles after the last edge_o; resumed wave -> active_o=1 and no period strobe on the first rising edge.
- REQ-036 rst_n pulsed low mid-wave -> outputs 0 immediately, then behaviour as in REQ-031/032.
